// File: rtl/adc_pkg.sv
// Shared types and widths for the ADC serial readout stage.
package adc_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      WAIT  = 2'd2
   } state_t;

   localparam int TDATA_W = 32;
   localparam int OVF_W   = 16;

endpackage

// File: rtl/adc_sck_gen.sv
// Serial clock generator: SCK_HALF cycles low, SCK_HALF cycles high, DATA_WIDTH periods.
// capture marks the last high cycle of each period; done marks it for the final bit.
module adc_sck_gen #(
   parameter int DATA_WIDTH = 18,
   parameter int SCK_HALF   = 2
) (
   input  logic aclk,
   input  logic aresetn,
   input  logic en,
   output logic sck,
   output logic capture,
   output logic done
);

   localparam int HW = (SCK_HALF > 1) ? $clog2(SCK_HALF) : 1;
   localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

   logic [HW-1:0] half_cnt;
   logic [BW-1:0] bit_cnt;
   logic          phase_end;

   assign phase_end = (half_cnt == HW'(SCK_HALF - 1));
   assign capture   = en & sck & phase_end;
   assign done      = capture & (bit_cnt == BW'(DATA_WIDTH - 1));

   // NOTE: all state here uses <= so every counter sees pre-edge values of its peers.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         half_cnt <= '0;
         bit_cnt  <= '0;
         sck      <= 1'b0;
      end else if (!en) begin
         half_cnt <= '0;
         bit_cnt  <= '0;
         sck      <= 1'b0;
      end else if (phase_end) begin
         half_cnt <= '0;
         sck      <= ~sck;
         if (sck) begin
            bit_cnt <= done ? '0 : bit_cnt + BW'(1);
         end
      end else begin
         half_cnt <= half_cnt + HW'(1);
      end
   end

endmodule

// File: rtl/adc_serial_capture.sv
// Clocks one ADC sample out over sck/sdo per trigger and presents it as an
// AXI4-Stream beat with packet framing and a registered last pulse.
module adc_serial_capture
   import adc_pkg::*;
#(
   parameter int DATA_WIDTH = 18,
   parameter int SCK_HALF   = 2
) (
   input  logic               aclk,
   input  logic               aresetn,
   input  logic               trigger,
   output logic               sck,
   input  logic               sdo,
   input  logic [31:0]        packet_len,
   input  logic               overflow_clr,
   output logic [TDATA_W-1:0] m_axis_tdata,
   output logic               m_axis_tvalid,
   input  logic               m_axis_tready,
   output logic               m_axis_tlast,
   output logic               last,
   output logic [OVF_W-1:0]   overflow_cnt
);

   state_t                state;
   logic [DATA_WIDTH-1:0] shift_reg;
   logic [DATA_WIDTH-1:0] sample_next;
   logic [DATA_WIDTH-1:0] load_data;
   logic                  capture;
   logic                  done;
   logic                  out_free;
   logic                  accept;
   logic                  load;
   logic                  load_last;
   logic [31:0]           len_eff;
   logic [31:0]           len_q;
   logic [31:0]           load_len;
   logic [31:0]           beat_idx;
   logic                  drop;

   adc_sck_gen #(
      .DATA_WIDTH (DATA_WIDTH),
      .SCK_HALF   (SCK_HALF)
   ) u_sck_gen (
      .aclk    (aclk),
      .aresetn (aresetn),
      .en      (state == SHIFT),
      .sck     (sck),
      .capture (capture),
      .done    (done)
   );

   // Cast keeps the low DATA_WIDTH bits, so this also works for DATA_WIDTH=1.
   assign sample_next = DATA_WIDTH'({shift_reg, sdo});

   assign accept    = m_axis_tvalid & m_axis_tready;
   assign out_free  = ~m_axis_tvalid | m_axis_tready;
   assign load      = out_free & (((state == SHIFT) & done) | (state == WAIT));
   assign load_data = (state == WAIT) ? shift_reg : sample_next;

   // Packet length is taken from the port only on the first beat of a packet.
   assign len_eff   = (packet_len == 32'd0) ? 32'd1 : packet_len;
   assign load_len  = (beat_idx == 32'd0) ? len_eff : len_q;
   assign load_last = (beat_idx == load_len - 32'd1);

   assign drop = trigger & (state != IDLE);

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state         <= IDLE;
         shift_reg     <= '0;
         m_axis_tvalid <= 1'b0;
         m_axis_tdata  <= '0;
         m_axis_tlast  <= 1'b0;
         beat_idx      <= '0;
         len_q         <= 32'd1;
      end else begin
         if (capture) begin
            shift_reg <= sample_next;
         end

         case (state)
            IDLE:    if (trigger) state <= SHIFT;
            SHIFT:   if (done) state <= out_free ? IDLE : WAIT;
            WAIT:    if (out_free) state <= IDLE;
            default: state <= IDLE;
         endcase

         // Single-entry output register: a load may coincide with the accept of the previous beat.
         if (load) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= TDATA_W'(load_data);
            m_axis_tlast  <= load_last;
            len_q         <= load_len;
            beat_idx      <= load_last ? 32'd0 : beat_idx + 32'd1;
         end else if (accept) begin
            m_axis_tvalid <= 1'b0;
         end
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         overflow_cnt <= '0;
         last         <= 1'b0;
      end else begin
         last <= accept & m_axis_tlast;
         if (overflow_clr) begin
            overflow_cnt <= '0;
         end else if (drop && !(&overflow_cnt)) begin
            overflow_cnt <= overflow_cnt + OVF_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_adc_serial_capture.sv
// Directed bench for adc_serial_capture with a behavioural MSB-first ADC on sck/sdo.
module tb_adc_serial_capture;

   localparam int DW = 18;
   localparam int H  = 2;

   logic        aclk          = 1'b0;
   logic        aresetn       = 1'b0;
   logic        trigger       = 1'b0;
   logic        sdo;
   logic [31:0] packet_len    = 32'd1;
   logic        overflow_clr  = 1'b0;
   logic        m_axis_tready = 1'b1;
   logic        sck;
   logic [31:0] m_axis_tdata;
   logic        m_axis_tvalid;
   logic        m_axis_tlast;
   logic        last;
   logic [15:0] overflow_cnt;

   int n_cmp      = 0;
   int n_err      = 0;
   int cyc        = 0;
   int rise_total = 0;
   int fall_total = 0;
   int rise_base  = 0;
   int fall_base  = 0;
   int last_seen  = 0;
   int bit_k;
   logic [DW-1:0] adc_word = '0;

   adc_serial_capture #(
      .DATA_WIDTH (DW),
      .SCK_HALF   (H)
   ) dut (
      .aclk          (aclk),
      .aresetn       (aresetn),
      .trigger       (trigger),
      .sck           (sck),
      .sdo           (sdo),
      .packet_len    (packet_len),
      .overflow_clr  (overflow_clr),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .m_axis_tlast  (m_axis_tlast),
      .last          (last),
      .overflow_cnt  (overflow_cnt)
   );

   always #5 aclk = ~aclk;

   always @(posedge aclk) cyc <= cyc + 1;
   always @(posedge sck) rise_total <= rise_total + 1;
   always @(negedge sck) fall_total <= fall_total + 1;

   // ADC model: presents bit k (MSB first) until the k-th falling edge of sck.
   always_comb begin
      bit_k = fall_total - fall_base;
      sdo   = 1'b0;
      if (bit_k >= 0 && bit_k < DW) sdo = adc_word[DW-1-bit_k];
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge aclk);
   endtask

   task automatic start_sample(input logic [DW-1:0] w);
      adc_word  = w;
      fall_base = fall_total;
      rise_base = rise_total;
      trigger   = 1'b1;
      @(negedge aclk);
      trigger   = 1'b0;
   endtask

   task automatic wait_valid(input string tag, output int t);
      t = -1;
      for (int i = 0; i < 200; i++) begin
         if (m_axis_tvalid) begin
            t = cyc;
            break;
         end
         @(negedge aclk);
      end
      check({tag, " tvalid"}, {31'd0, m_axis_tvalid}, 32'd1);
   endtask

   // Consumes one beat with tready=1 and checks data, tlast and the following last pulse.
   task automatic beat(input string tag, input logic [DW-1:0] w, input logic exp_last);
      check({tag, " tdata"}, m_axis_tdata, {{(32-DW){1'b0}}, w});
      check({tag, " tlast"}, {31'd0, m_axis_tlast}, {31'd0, exp_last});
      @(negedge aclk);
      if (last) last_seen++;
      check({tag, " last"}, {31'd0, last}, {31'd0, exp_last});
      check({tag, " tvalid drop"}, {31'd0, m_axis_tvalid}, 32'd0);
   endtask

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int t;
      logic [DW-1:0] w;

      tick(3);
      check("reset sck", {31'd0, sck}, 32'd0);
      check("reset tvalid", {31'd0, m_axis_tvalid}, 32'd0);
      check("reset tdata", m_axis_tdata, 32'd0);
      check("reset tlast", {31'd0, m_axis_tlast}, 32'd0);
      check("reset last", {31'd0, last}, 32'd0);
      check("reset overflow", {16'd0, overflow_cnt}, 32'd0);
      aresetn = 1'b1;

      // Single sample: trigger sampled at edge 10, tvalid expected at edge 82.
      while (cyc < 9) @(negedge aclk);
      start_sample(18'h2A5A5);
      wait_valid("t1", t);
      check("t1 latency", t, 32'd82);
      beat("t1", 18'h2A5A5, 1'b1);
      check("t1 sck rises", rise_total - rise_base, 32'd18);
      check("t1 sck idle", {31'd0, sck}, 32'd0);

      // Packet framing, packet_len=4.
      packet_len = 32'd4;
      last_seen  = 0;
      for (int i = 0; i < 8; i++) begin
         w = DW'(32'h12345 + i * 32'h03C3C);
         start_sample(w);
         wait_valid("t2", t);
         beat("t2", w, (i % 4) == 3);
      end
      check("t2 last pulses", last_seen, 32'd2);

      // Backpressure: one held beat, one sample in WAIT, third trigger dropped.
      packet_len    = 32'd1;
      m_axis_tready = 1'b0;
      start_sample(18'h3FFFF);
      wait_valid("t3a", t);
      check("t3a tdata", m_axis_tdata, 32'h3FFFF);
      start_sample(18'h00F0F);
      tick(80);
      check("t3 stall tvalid", {31'd0, m_axis_tvalid}, 32'd1);
      check("t3 stall tdata", m_axis_tdata, 32'h3FFFF);
      check("t3b sck rises", rise_total - rise_base, 32'd18);
      trigger = 1'b1;
      @(negedge aclk);
      trigger = 1'b0;
      check("t3 overflow", {16'd0, overflow_cnt}, 32'd1);
      m_axis_tready = 1'b1;
      @(negedge aclk);
      check("t3b tvalid", {31'd0, m_axis_tvalid}, 32'd1);
      check("t3b tdata", m_axis_tdata, 32'h00F0F);
      check("t3a last", {31'd0, last}, 32'd1);
      @(negedge aclk);
      check("t3 drained", {31'd0, m_axis_tvalid}, 32'd0);
      check("t3b last", {31'd0, last}, 32'd1);
      @(negedge aclk);
      check("t3 last off", {31'd0, last}, 32'd0);

      // Trigger during SHIFT, then clear colliding with a drop.
      overflow_clr = 1'b1;
      @(negedge aclk);
      overflow_clr = 1'b0;
      check("t4 clear", {16'd0, overflow_cnt}, 32'd0);
      start_sample(18'h15555);
      tick(4);
      trigger = 1'b1;
      @(negedge aclk);
      trigger = 1'b0;
      check("t4 overflow", {16'd0, overflow_cnt}, 32'd1);
      wait_valid("t4", t);
      beat("t4", 18'h15555, 1'b1);
      check("t4 sck rises", rise_total - rise_base, 32'd18);
      tick(80);
      check("t4 single beat", {31'd0, m_axis_tvalid}, 32'd0);
      start_sample(18'h0A0A0);
      tick(2);
      trigger      = 1'b1;
      overflow_clr = 1'b1;
      @(negedge aclk);
      trigger      = 1'b0;
      overflow_clr = 1'b0;
      check("t4 clear wins", {16'd0, overflow_cnt}, 32'd0);
      wait_valid("t4d", t);
      beat("t4d", 18'h0A0A0, 1'b1);

      // Reset mid-SHIFT with a beat held in the output register.
      m_axis_tready = 1'b0;
      start_sample(18'h12345);
      wait_valid("t5e", t);
      check("t5e tdata", m_axis_tdata, 32'h12345);
      start_sample(18'h2FFFF);
      for (int i = 0; i < 20 && !sck; i++) @(negedge aclk);
      check("t5 sck high", {31'd0, sck}, 32'd1);
      aresetn = 1'b0;
      #1;
      check("t5 rst sck", {31'd0, sck}, 32'd0);
      check("t5 rst tvalid", {31'd0, m_axis_tvalid}, 32'd0);
      check("t5 rst tdata", m_axis_tdata, 32'd0);
      tick(3);
      aresetn       = 1'b1;
      m_axis_tready = 1'b1;
      tick(1);
      start_sample(18'h054AB);
      wait_valid("t5f", t);
      beat("t5f", 18'h054AB, 1'b1);
      check("t5f sck rises", rise_total - rise_base, 32'd18);

      // packet_len=0 behaves as 1.
      packet_len = 32'd0;
      for (int i = 0; i < 3; i++) begin
         w = DW'(32'h20001 + i * 32'h01111);
         start_sample(w);
         wait_valid("t6", t);
         beat("t6", w, 1'b1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
